// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 matrix keypad by driving one column low at a time. The row lines
// are sampled once per column step and combined into a four-column "frame".
// Frames with exactly one closed contact are debounced: DEBOUNCE identical
// frames accept a key, and DEBOUNCE empty frames release it. Each accepted key
// is handed to a consumer through a valid/ack holding register. If a new key
// arrives while an earlier one is still unconsumed, it is dropped and a sticky
// overrun flag is raised.
//
// Parameters
//   SCAN_DIV  clk cycles per column step (2..65535); also the row settling time
//   DEBOUNCE  identical frames needed to accept a press or a release (1..15)
//
// Ports
//   clk        clock; all state changes on its rising edge
//   res        asynchronous active-low reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   column drive, active-low, one-cold
//   key_code   accepted key, 4*row_index + col_index
//   key_valid  key_code holds a key the consumer has not yet taken
//   key_ack    consumer takes key_code (ignored while key_valid is low)
//   overrun    sticky: an accepted key was dropped; cleared by an accepted ack
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       res,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       overrun
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DEB      = 4'(DEBOUNCE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAND    = 2'd1,
        S_PRESSED = 2'd2
    } state_t;

    // Number of low bits in a row sample, saturated at 2 ("more than one").
    function automatic logic [1:0] low_count(input logic [3:0] r);
        logic [2:0] n;
        n = 3'd0;
        for (int k = 0; k < 4; k++) begin
            n = n + {2'b00, ~r[k]};
        end
        return (n > 3'd1) ? 2'd2 : n[1:0];
    endfunction

    // Index of the lowest-numbered low row bit; only meaningful when exactly
    // one bit is low.
    function automatic logic [1:0] low_row(input logic [3:0] r);
        logic [1:0] i;
        i = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (!r[k]) begin
                i = 2'(k);
            end
        end
        return i;
    endfunction

    // Saturating add of two 0/1/many counts.
    function automatic logic [1:0] sat_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > 3'd1) ? 2'd2 : s[1:0];
    endfunction

    logic [3:0]  row_p0;
    logic [3:0]  row_p1;
    logic [15:0] presc;
    logic        tick;
    logic [1:0]  idx;

    logic [1:0]  frame_low;
    logic [3:0]  frame_code;

    logic [1:0]  smp_low;
    logic [1:0]  tot_low;
    logic [3:0]  hit_code;
    logic        frame_close;
    logic        frame_key;
    logic        frame_none;
    logic        accept;

    state_t      state;
    logic [3:0]  cand;
    logic [3:0]  cnt;
    logic [3:0]  rel_cnt;

    // ---- stage p0/p1: row synchronizer (released level is all-ones) ----
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            row_p0 <= 4'hF;
            row_p1 <= 4'hF;
        end else begin
            row_p0 <= row;
            row_p1 <= row_p0;
        end
    end

    // ---- column step timing: prescaler, column index and column drive ----
    assign tick = (presc == DIV_LAST);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            presc <= 16'd0;
            idx   <= 2'd0;
            col   <= 4'b1110;
        end else begin
            if (tick) begin
                presc <= 16'd0;
                idx   <= idx + 2'd1;
                // Rotating the one-cold pattern keeps col == ~(1 << idx).
                col   <= {col[2:0], col[3]};
            end else begin
                presc <= presc + 16'd1;
            end
        end
    end

    // ---- frame assembly: the sample on a tick belongs to the column being
    // driven before the index advances ----
    always_comb begin
        smp_low     = low_count(row_p1);
        tot_low     = sat_add(frame_low, smp_low);
        hit_code    = (smp_low == 2'd1) ? {low_row(row_p1), idx} : frame_code;
        frame_close = tick && (idx == 2'd3);
        frame_key   = frame_close && (tot_low == 2'd1);
        frame_none  = frame_close && (tot_low != 2'd1);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            frame_low  <= 2'd0;
            frame_code <= 4'd0;
        end else if (tick) begin
            if (idx == 2'd3) begin
                frame_low  <= 2'd0;
                frame_code <= 4'd0;
            end else begin
                frame_low  <= tot_low;
                frame_code <= hit_code;
            end
        end
    end

    // Acceptance is decided in the frame-close cycle so that the FSM and the
    // holding register update on the same edge.
    always_comb begin
        accept = 1'b0;
        if (frame_key) begin
            if (state == S_IDLE) begin
                accept = (DEB == 4'd1);
            end else if (state == S_CAND) begin
                accept = (hit_code == cand) && ((cnt + 4'd1) == DEB);
            end
        end
    end

    // ---- debounce FSM and key holding register ----
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= S_IDLE;
            cand      <= 4'd0;
            cnt       <= 4'd0;
            rel_cnt   <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (frame_key) begin
                        cand    <= hit_code;
                        cnt     <= 4'd1;
                        rel_cnt <= 4'd0;
                        state   <= accept ? S_PRESSED : S_CAND;
                    end
                end
                S_CAND: begin
                    if (frame_key) begin
                        if (accept) begin
                            state   <= S_PRESSED;
                            cnt     <= 4'd0;
                            rel_cnt <= 4'd0;
                        end else if (hit_code == cand) begin
                            cnt <= cnt + 4'd1;
                        end else begin
                            cand <= hit_code;
                            cnt  <= 4'd1;
                        end
                    end else if (frame_none) begin
                        state <= S_IDLE;
                        cnt   <= 4'd0;
                    end
                end
                S_PRESSED: begin
                    // Any key frame restarts the release count; there is no
                    // auto-repeat, so nothing is accepted from this state.
                    if (frame_key) begin
                        rel_cnt <= 4'd0;
                    end else if (frame_none) begin
                        if ((rel_cnt + 4'd1) == DEB) begin
                            state   <= S_IDLE;
                            rel_cnt <= 4'd0;
                        end else begin
                            rel_cnt <= rel_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (accept) begin
                if (!key_valid || key_ack) begin
                    key_code  <= hit_code;
                    key_valid <= 1'b1;
                end
                // A simultaneous ack frees the register, so nothing is lost.
                if (key_valid && key_ack) begin
                    overrun <= 1'b0;
                end else if (key_valid) begin
                    overrun <= 1'b1;
                end
            end else if (key_valid && key_ack) begin
                key_valid <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Drives a simulated 4x4 keypad (a set of held keys shorted onto the driven
// column) and compares the scanner outputs on every falling edge against a
// behavioural model built from the scanning rules: column index from the
// number of edges since reset, frame results from four delayed row samples,
// and debouncing expressed as run lengths of identical frame results.
// Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SD    = 4;
    localparam int DEB   = 2;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack = 1'b0;
    logic        overrun;
    logic [15:0] keys = 16'h0000;

    int errors = 0;
    int checks = 0;

    logic [3:0] col_seq [16] = '{4'hE, 4'hE, 4'hE, 4'hD, 4'hD, 4'hD, 4'hD, 4'hB,
                                 4'hB, 4'hB, 4'hB, 4'h7, 4'h7, 4'h7, 4'h7, 4'hE};

    // Model state
    int         m;
    logic [3:0] hist0, hist1;
    logic [3:0] samp [4];
    int         m_last;
    int         m_run;
    bit         m_held;
    logic [3:0] mc;
    bit         mv, mo;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
        .clk       (clk),
        .res       (res),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .overrun   (overrun)
    );

    // Keypad: a held key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int k = 0; k < 16; k++) begin
            if (keys[k] && !col[k % 4]) row[k / 4] = 1'b0;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m = 0;
        hist0 = 4'hF;
        hist1 = 4'hF;
        for (int c = 0; c < 4; c++) samp[c] = 4'hF;
        m_last = -1;
        m_run = 0;
        m_held = 0;
        mc = 4'd0;
        mv = 0;
        mo = 0;
    endtask

    // Advance the model across one rising edge seeing row_in / ack_in.
    task automatic model_step(input logic [3:0] row_in, input logic ack_in);
        logic [3:0] sample;
        int pos, cidx, nlow, code, rk;
        bit acc;
        int acc_code;
        sample = hist1;          // rows reach the scanner two edges late
        hist1 = hist0;
        hist0 = row_in;
        pos  = m % SD;
        cidx = (m / SD) % 4;
        acc = 0;
        acc_code = 0;
        if (pos == SD - 1) begin
            samp[cidx] = sample;
            if (cidx == 3) begin
                nlow = 0;
                code = 0;
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        if (!samp[c][r]) begin
                            nlow++;
                            code = 4 * r + c;
                        end
                rk = (nlow == 1) ? code : -1;
                if (rk == m_last) m_run++;
                else begin
                    m_last = rk;
                    m_run = 1;
                end
                if (!m_held && rk >= 0 && m_run == DEB) begin
                    acc = 1;
                    acc_code = rk;
                    m_held = 1;
                end else if (m_held && rk < 0 && m_run == DEB) begin
                    m_held = 0;
                end
            end
        end
        if (acc) begin
            if (!mv) begin
                mc = 4'(acc_code);
                mv = 1;
            end else if (ack_in) begin
                mc = 4'(acc_code);
                mv = 1;
                mo = 0;
            end else begin
                mo = 1;
            end
        end else if (mv && ack_in) begin
            mv = 0;
            mo = 0;
        end
        m++;
    endtask

    task automatic monitor();
        logic [3:0] one;
        logic [3:0] ecol;
        forever begin
            @(negedge clk);
            if (!res) model_reset();
            one = 4'b0001;
            ecol = ~(one << ((m / SD) % 4));
            check("col", 8'(col), 8'(ecol));
            check("key_code", 8'(key_code), 8'(mc));
            check("key_valid", 8'(key_valid), 8'(mv));
            check("overrun", 8'(overrun), 8'(mo));
            if (res) model_step(row, key_ack);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic ack_once();
        key_ack = 1'b1;
        wait_cyc(1);
        key_ack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"}, 8'(col), 8'h0E);
        check({tag, "_code"}, 8'(key_code), 8'h00);
        check({tag, "_valid"}, 8'(key_valid), 8'h00);
        check({tag, "_ovr"}, 8'(overrun), 8'h00);
    endtask

    initial begin
        bit found;
        int hold;
        int r;
        #1 res = 1'b0;
        fork
            monitor();
        join_none
        wait_cyc(3);
        check_reset_outputs("reset");
        res = 1'b1;

        // Idle scan: column pattern after release, then 200 idle cycles.
        for (int i = 0; i < 16; i++) begin
            wait_cyc(1);
            check("col_seq", 8'(col), 8'(col_seq[i]));
        end
        wait_cyc(184);
        check("idle_valid", 8'(key_valid), 8'h00);

        // Single press of key 6, ack, keep holding.
        keys = 16'h0040;
        wait_cyc(4 * FRAME);
        check("press6_valid", 8'(key_valid), 8'h01);
        check("press6_code", 8'(key_code), 8'h06);
        ack_once();
        check("ack6_valid", 8'(key_valid), 8'h00);
        wait_cyc(3 * FRAME);
        check("hold6_no_repeat", 8'(key_valid), 8'h00);
        keys = 16'h0000;
        wait_cyc(3 * FRAME);

        // Bounce: one frame on, one frame off, five times.
        for (int i = 0; i < 5; i++) begin
            keys = 16'h0040;
            wait_cyc(FRAME);
            keys = 16'h0000;
            wait_cyc(FRAME);
        end
        check("bounce_valid", 8'(key_valid), 8'h00);
        wait_cyc(2 * FRAME);

        // Overrun: key 6 unconsumed, then key 9 accepted.
        keys = 16'h0040;
        wait_cyc(4 * FRAME);
        check("ovr_first_code", 8'(key_code), 8'h06);
        keys = 16'h0000;
        wait_cyc(3 * FRAME);
        keys = 16'h0200;
        wait_cyc(3 * FRAME);
        check("ovr_code_kept", 8'(key_code), 8'h06);
        check("ovr_valid", 8'(key_valid), 8'h01);
        check("ovr_flag", 8'(overrun), 8'h01);
        ack_once();
        check("ovr_ack_valid", 8'(key_valid), 8'h00);
        check("ovr_ack_flag", 8'(overrun), 8'h00);
        keys = 16'h0000;
        wait_cyc(3 * FRAME);

        // Ghost: keys 0 and 5 together, then 0 alone.
        keys = 16'h0021;
        wait_cyc(4 * FRAME);
        check("ghost_valid", 8'(key_valid), 8'h00);
        keys = 16'h0001;
        wait_cyc(4 * FRAME);
        check("ghost_rel_valid", 8'(key_valid), 8'h01);
        check("ghost_rel_code", 8'(key_code), 8'h00);
        ack_once();
        keys = 16'h0000;
        wait_cyc(3 * FRAME);

        // Reset while a candidate is being debounced.
        keys = 16'h0040;
        found = 0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            wait_cyc(1);
            if (!m_held && m_last == 6 && m_run == 1) found = 1;
        end
        check("cand_reached", 8'(found), 8'h01);
        res = 1'b0;
        wait_cyc(2);
        check_reset_outputs("midreset");
        res = 1'b1;
        wait_cyc(31);
        check("post_reset_early", 8'(key_valid), 8'h00);
        wait_cyc(1);
        check("post_reset_valid", 8'(key_valid), 8'h01);
        check("post_reset_code", 8'(key_code), 8'h06);
        ack_once();
        keys = 16'h0000;
        wait_cyc(3 * FRAME);

        // Acceptance and ack on the same edge (phase known after reset).
        res = 1'b0;
        wait_cyc(2);
        keys = 16'h0008;
        res = 1'b1;
        wait_cyc(32);
        check("same_first_valid", 8'(key_valid), 8'h01);
        check("same_first_code", 8'(key_code), 8'h03);
        keys = 16'h0000;
        wait_cyc(32);
        keys = 16'h0002;
        wait_cyc(31);
        check("same_pre_code", 8'(key_code), 8'h03);
        ack_once();
        check("same_code", 8'(key_code), 8'h01);
        check("same_valid", 8'(key_valid), 8'h01);
        check("same_ovr", 8'(overrun), 8'h00);
        ack_once();
        check("same_ack_valid", 8'(key_valid), 8'h00);
        keys = 16'h0000;
        wait_cyc(3 * FRAME);

        // Randomized presses, ghosts, acks and occasional resets.
        for (int it = 0; it < 120; it++) begin
            r = $urandom_range(0, 9);
            if (r < 3) keys = 16'h0000;
            else if (r < 9) keys = 16'h0001 << $urandom_range(0, 15);
            else keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            hold = $urandom_range(8, 80);
            for (int c = 0; c < hold; c++) begin
                key_ack = ($urandom_range(0, 3) == 0);
                wait_cyc(1);
            end
            if ($urandom_range(0, 29) == 0) begin
                res = 1'b0;
                wait_cyc(2);
                res = 1'b1;
            end
        end
        key_ack = 1'b0;
        keys = 16'h0000;
        wait_cyc(3 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clk cycles per column step, legal range 2..65535.
REQ-002 SHALL have parameter DEBOUNCE, default 4: consecutive identical scan frames required to accept a press or a release, legal range 1..15.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port res  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port row  input  4: keypad rows, active-low, asynchronous to clk.
REQ-006 SHALL have port col  output  4: column drive, active-low, exactly one bit low (one-cold).
REQ-007 SHALL have port key_code  output  4: accepted key, code = 4*row_index + col_index.
REQ-008 SHALL have port key_valid  output  1: key_code holds an unconsumed key.
REQ-009 SHALL have port key_ack  input  1: consumer accepts key_code.
REQ-010 SHALL have port overrun  output  1: an accepted key was dropped because key_valid was still high.

Function
REQ-011 SHALL pass row through a 2-flop synchronizer before any use.
REQ-012 SHALL run a prescaler counting 0..SCAN_DIV-1, wrapping to 0; tick = 1 in the cycle the count equals SCAN_DIV-1.
REQ-013 SHALL hold a 2-bit column index that increments on tick and wraps 3->0; col = ~(4'b0001 << index).
REQ-014 SHALL sample the synchronized row on tick, attributing the sample to the current index before it advances; settling time is therefore SCAN_DIV cycles.
REQ-015 SHALL close a frame on the tick where index = 3; frame result = NONE if no bit was low, KEY(code) if exactly one bit was low across all 4 columns, NONE if more than one was low (ghost rejection).
REQ-016 SHALL implement the FSM IDLE, CAND, PRESSED, evaluated only at frame close.
REQ-017 IDLE: KEY(c) -> CAND with cand=c, cnt=1; NONE -> stay.
REQ-018 CAND: KEY(cand) -> cnt+1; when cnt reaches DEBOUNCE -> PRESSED and accept cand; KEY(other) -> cand=other, cnt=1; NONE -> IDLE.
REQ-019 DEBOUNCE=1 SHALL accept a key on the first frame it appears, entering PRESSED directly from IDLE.
REQ-020 PRESSED: NONE increments a release count; DEBOUNCE consecutive NONE frames -> IDLE; any KEY frame clears the release count. No auto-repeat; exactly one acceptance per press.
REQ-021 On acceptance with key_valid = 0, SHALL load key_code and set key_valid on the next clk edge.
REQ-022 key_valid SHALL remain high until an edge where key_valid = 1 and key_ack = 1, then clear; key_ack with key_valid = 0 SHALL be ignored.
REQ-023 On acceptance with key_valid = 1 and key_ack = 0, key_code SHALL NOT change and overrun SHALL be set.
REQ-024 On acceptance and ack in the same cycle, key_code SHALL load the new key, key_valid SHALL stay 1, and overrun SHALL NOT be set.
REQ-025 overrun SHALL be sticky and clear only on an edge where a key_ack is accepted or on reset.

Reset
REQ-026 While res = 0: col = 4'b1110; key_code = 0; key_valid = 0; overrun = 0; FSM = IDLE; prescaler, index and all counts = 0; synchronizer flops = 1 (released).
REQ-027 Reset assertion mid-frame or mid-debounce SHALL discard all partial frame and candidate state, with no output glitch after deassertion.
REQ-028 The first tick SHALL occur SCAN_DIV cycles after reset deassertion.

Verification (SCAN_DIV=4, DEBOUNCE=2)
REQ-029 Idle: no key, 200 cycles -> col cycles 1110,1101,1011,0111, each held 4 cycles; key_valid stays 0.
REQ-030 Hold row1/col2 for 3 frames -> key_valid rises after frame-2 close with key_code = 6; ack -> key_valid clears next edge; continued holding -> no second event.
REQ-031 Bounce: key present 1 frame, absent 1 frame, repeated 5 times -> key_valid never asserts.
REQ-032 Press 6, no ack, release 2 frames, press 9 for 2 frames -> key_code stays 6, overrun = 1; ack -> key_valid = 0, overrun = 0.
REQ-033 Keys 0 and 5 held together for 4 frames -> no acceptance; release 5 -> key 0 accepted after 2 frames.
REQ-034 Assert res during CAND with cnt = 1, then release -> all outputs at reset values; key still held -> accepted 2 full frames after release.
